// File: rtl/rec_capture_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rec_sched_pkg
//  Purpose  : Shared constants, types and helpers for the recovered-data
//             capture scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package rec_sched_pkg;

    // Default width of a recovered data word
    localparam int DW_DEFAULT = 14;

    // Width of a channel index; never narrower than one bit
    function automatic int ch_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Output slot occupancy
    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage : rec_sched_pkg
`default_nettype wire

// File: rtl/rec_capture_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : rec_capture_sched_if
//  Purpose  : Valid/ready output stream carrying one standardised word and
//             the channel it came from.
//  Revision : 1.0  initial release
// ============================================================================
interface rec_capture_sched_if
    import rec_sched_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int CH_W = 2
);
    logic [DW-1:0]   data_stand;
    logic [CH_W-1:0] stand_ch;
    logic            stand_valid;
    logic            stand_ready;

    modport master (
        output data_stand,
        output stand_ch,
        output stand_valid,
        input  stand_ready
    );

    modport slave (
        input  data_stand,
        input  stand_ch,
        input  stand_valid,
        output stand_ready
    );
endinterface : rec_capture_sched_if
`default_nettype wire

// File: rtl/rec_capture_sched_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : rec_edge_sync
//  Purpose  : Multi-flop synchroniser for one recovered strobe followed by a
//             rising-edge detector gated by the channel enable.
//  Revision : 1.0  initial release
// ============================================================================
module rec_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clock_50,
    input  wire logic reset_n,
    input  wire logic strobe,
    input  wire logic en,
    output logic      rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Shift the async strobe through the chain; remember the last synced value
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], strobe};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    // prev resets low, so a strobe already high at reset release yields one edge
    assign rise = sync[SYNC_STAGES-1] & ~prev & en;

endmodule : rec_edge_sync
`default_nettype wire

// File: rtl/rec_capture_sched.sv
`default_nettype none
// ============================================================================
//  Module   : rec_capture_sched
//  Purpose  : Captures words from N_CH asynchronous recovered-data channels
//             and funnels them round-robin into one valid/ready output
//             register, tagged with the source channel.
//  Revision : 1.0  initial release
// ============================================================================
module rec_capture_sched
    import rec_sched_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DW          = DW_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic                 clock_50,
    input  wire logic                 reset_n,
    input  wire logic [N_CH-1:0]      clock_recovery,
    input  wire logic [N_CH*DW-1:0]   data_rec,
    input  wire logic [N_CH-1:0]      ch_en,
    input  wire logic                 clr_ovf,
    rec_capture_sched_if.master       stand,
    output logic      [N_CH-1:0]      pending,
    output logic      [N_CH-1:0]      ovf_flag
);

    localparam int              CH_W     = ch_w(N_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);
    localparam logic [CH_W:0]   N_CH_EXT = (CH_W + 1)'(N_CH);

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] granted;
    logic [N_CH-1:0] pending_d;
    logic [N_CH-1:0] ovf_set;
    logic [DW-1:0]   hold [N_CH];

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] grant_idx;
    logic            grant_any;

    slot_state_t     slot_q;
    slot_state_t     slot_d;
    logic            out_free;
    logic            load_out;
    logic [DW-1:0]   data_q;
    logic [CH_W-1:0] ch_q;

    // ------------------------------------------------------------------
    // Per-channel synchroniser, holding register and pending/ovf logic
    // ------------------------------------------------------------------
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        rec_edge_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_edge_sync (
            .clock_50 (clock_50),
            .reset_n  (reset_n),
            .strobe   (clock_recovery[c]),
            .en       (ch_en[c]),
            .rise     (rise[c])
        );

        assign granted[c] = load_out && (grant_idx == CH_W'(c));

        // A fresh edge always re-arms pending, even if this cycle grants it
        assign pending_d[c] = rise[c] | (pending[c] & ~granted[c]);

        // Overwrite only when the old word is still waiting and not leaving now
        assign ovf_set[c] = rise[c] & pending[c] & ~granted[c];

        // Newest word wins; the granted word was already read this cycle
        always_ff @(posedge clock_50 or negedge reset_n) begin
            if (!reset_n) begin
                hold[c] <= '0;
            end else if (rise[c]) begin
                hold[c] <= data_rec[c*DW +: DW];
            end
        end
    end : g_ch

    // Pending vector and sticky overflow; a new overwrite beats clr_ovf
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            ovf_flag <= '0;
        end else begin
            pending  <= pending_d;
            ovf_flag <= ovf_set | (ovf_flag & ~{N_CH{clr_ovf}});
        end
    end

    // ------------------------------------------------------------------
    // Round-robin picker: first pending channel at or after ptr, cyclic.
    // Scanning downward lets the nearest candidate overwrite the others.
    // ------------------------------------------------------------------
    always_comb begin
        logic [CH_W:0] idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (CH_W + 1)'(i);
            if (idx >= N_CH_EXT) begin
                idx = idx - N_CH_EXT;
            end
            if (pending[idx[CH_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = idx[CH_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output slot FSM
    // ------------------------------------------------------------------
    // Slot occupancy register
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            slot_q <= SLOT_EMPTY;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Slot next state and load strobe; a stalled full slot freezes everything
    always_comb begin
        slot_d   = slot_q;
        out_free = (slot_q == SLOT_EMPTY) | stand.stand_ready;
        load_out = out_free & grant_any;
        case (slot_q)
            SLOT_EMPTY: begin
                if (grant_any) begin
                    slot_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (stand.stand_ready && !grant_any) begin
                    slot_d = SLOT_EMPTY;
                end
            end
            default: slot_d = SLOT_EMPTY;
        endcase
    end

    // Output word/channel register and round-robin pointer advance
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            ch_q   <= '0;
            ptr    <= '0;
        end else if (load_out) begin
            data_q <= hold[grant_idx];
            ch_q   <= grant_idx;
            ptr    <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
        end
    end

    assign stand.data_stand  = data_q;
    assign stand.stand_ch    = ch_q;
    assign stand.stand_valid = (slot_q == SLOT_FULL);

endmodule : rec_capture_sched
`default_nettype wire

// File: tb/tb_rec_capture_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rec_capture_sched
//  Purpose  : Self-checking bench for rec_capture_sched with an expected-word
//             scoreboard filled by the stimulus and drained by the monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rec_capture_sched;
    import rec_sched_pkg::*;

    localparam int N_CH        = 4;
    localparam int DW          = 14;
    localparam int SYNC_STAGES = 2;
    localparam int CH_W        = 2;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [DW-1:0]   data;
    } exp_t;

    logic               clock_50 = 1'b0;
    logic               reset_n;
    logic [N_CH-1:0]    clock_recovery;
    logic [N_CH*DW-1:0] data_rec;
    logic [N_CH-1:0]    ch_en;
    logic               clr_ovf;
    logic [N_CH-1:0]    pending;
    logic [N_CH-1:0]    ovf_flag;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    rec_capture_sched_if #(.DW(DW), .CH_W(CH_W)) sif ();

    rec_capture_sched #(
        .N_CH        (N_CH),
        .DW          (DW),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock_50       (clock_50),
        .reset_n        (reset_n),
        .clock_recovery (clock_recovery),
        .data_rec       (data_rec),
        .ch_en          (ch_en),
        .clr_ovf        (clr_ovf),
        .stand          (sif),
        .pending        (pending),
        .ovf_flag       (ovf_flag)
    );

    always #5 clock_50 = ~clock_50;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n clocks; stimulus and checks sit 2 ns after the rising edge
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock_50);
            #2;
        end
    endtask

    task automatic set_data(input int c, input logic [DW-1:0] d);
        data_rec[c*DW +: DW] = d;
    endtask

    task automatic push_exp(input int c, input logic [DW-1:0] d);
        exp_t e;
        e.ch   = CH_W'(c);
        e.data = d;
        sb.push_back(e);
    endtask

    // All four strobes rise together; expect grants 0,1,2,3 back to back
    task automatic burst(input logic [DW-1:0] base);
        for (int c = 0; c < N_CH; c++) begin
            set_data(c, base + DW'(c));
            push_exp(c, base + DW'(c));
        end
        clock_recovery = '1;
        tick(3);
        check_value("burst_all_pending", pending, 4'hF);
        for (int c = 0; c < N_CH; c++) begin
            tick();
            check_value("burst_valid", sif.stand_valid, 1'b1);
            check_value("burst_ch_order", sif.stand_ch, c);
        end
        tick();
        check_value("burst_idle", sif.stand_valid, 1'b0);
        clock_recovery = '0;
        tick(3);
    endtask

    // Monitor: every accepted word must match the head of the scoreboard
    always @(negedge clock_50) begin
        if (reset_n && sif.stand_valid && sif.stand_ready) begin
            if (sb.size() == 0) begin
                check_value("word_without_expectation", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check_value("out_ch", sif.stand_ch, mon_e.ch);
                check_value("out_data", sif.data_stand, mon_e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        clock_recovery  = '0;
        data_rec        = '0;
        ch_en           = '1;
        clr_ovf         = 1'b0;
        sif.stand_ready = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick();

        // Reset state
        check_value("rst_valid", sif.stand_valid, 1'b0);
        check_value("rst_data", sif.data_stand, 0);
        check_value("rst_ch", sif.stand_ch, 0);
        check_value("rst_pending", pending, 0);
        check_value("rst_ovf", ovf_flag, 0);

        // Round robin from ptr=0, twice
        burst(14'h0001);
        burst(14'h0005);

        // Single edge on ch2, latency SYNC_STAGES+2
        set_data(2, 14'h1ABC);
        push_exp(2, 14'h1ABC);
        clock_recovery[2] = 1'b1;
        tick(3);
        check_value("t1_pending_before_out", pending, 4'b0100);
        check_value("t1_not_yet_valid", sif.stand_valid, 1'b0);
        tick();
        check_value("t1_latency_valid", sif.stand_valid, 1'b1);
        check_value("t1_ch", sif.stand_ch, 2);
        check_value("t1_data", sif.data_stand, 14'h1ABC);
        tick();
        check_value("t1_pulse_one_clk", sif.stand_valid, 1'b0);
        clock_recovery[2] = 1'b0;
        tick(3);

        // Backpressure with two words (ptr=3 so ch0 goes first)
        sif.stand_ready = 1'b0;
        set_data(0, 14'h0111);
        set_data(1, 14'h0222);
        push_exp(0, 14'h0111);
        push_exp(1, 14'h0222);
        clock_recovery[1:0] = 2'b11;
        tick(4);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_value("t3_hold_valid", sif.stand_valid, 1'b1);
            check_value("t3_hold_data", sif.data_stand, 14'h0111);
            check_value("t3_hold_pending", pending, 4'b0010);
        end
        sif.stand_ready = 1'b1;
        tick();
        check_value("t3_second_ch", sif.stand_ch, 1);
        tick();
        check_value("t3_drained", sif.stand_valid, 1'b0);
        clock_recovery[1:0] = 2'b00;
        tick(3);

        // Overwrite on ch1 while the output slot is stalled by a ch0 word
        sif.stand_ready = 1'b0;
        set_data(0, 14'h0CCC);
        push_exp(0, 14'h0CCC);
        clock_recovery[0] = 1'b1;
        tick(4);
        check_value("t4_slot_full", sif.stand_valid, 1'b1);
        set_data(1, 14'h0AAA);
        clock_recovery[1] = 1'b1;
        tick(3);
        check_value("t4_first_pending", pending, 4'b0010);
        check_value("t4_no_ovf_yet", ovf_flag, 0);
        clock_recovery[1] = 1'b0;
        tick(3);
        set_data(1, 14'h0BBB);
        push_exp(1, 14'h0BBB);
        clock_recovery[1] = 1'b1;
        tick(3);
        check_value("t4_ovf_set", ovf_flag, 4'b0010);
        check_value("t4_still_pending", pending, 4'b0010);
        sif.stand_ready = 1'b1;
        tick(2);
        check_value("t4_drained", sif.stand_valid, 1'b0);
        check_value("t4_ovf_sticky", ovf_flag, 4'b0010);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_value("t4_ovf_cleared", ovf_flag, 0);
        clock_recovery[1:0] = 2'b00;
        tick(3);

        // Reset mid-transfer with valid=1 and pending=0110
        sif.stand_ready = 1'b0;
        set_data(0, 14'h0101);
        set_data(1, 14'h0202);
        set_data(2, 14'h0303);
        clock_recovery[0] = 1'b1;
        tick(4);
        clock_recovery[2:1] = 2'b11;
        tick(3);
        check_value("t5_pre_valid", sif.stand_valid, 1'b1);
        check_value("t5_pre_pending", pending, 4'b0110);
        #1;
        reset_n = 1'b0;
        #1;
        check_value("t5_async_valid", sif.stand_valid, 1'b0);
        check_value("t5_async_data", sif.data_stand, 0);
        check_value("t5_async_ch", sif.stand_ch, 0);
        check_value("t5_async_pending", pending, 0);
        check_value("t5_async_ovf", ovf_flag, 0);
        tick(2);
        sif.stand_ready = 1'b1;
        push_exp(0, 14'h0101);
        push_exp(1, 14'h0202);
        push_exp(2, 14'h0303);
        reset_n = 1'b1;
        tick(10);
        check_value("t5_one_capture_each", 32'(sb.size()), 0);
        check_value("t5_pending_clear", pending, 0);
        clock_recovery[2:0] = 3'b000;
        tick(3);

        // Disabled ch3 toggles; ch0 still delivers
        ch_en = 4'b0111;
        set_data(3, 14'h3333);
        set_data(0, 14'h0444);
        push_exp(0, 14'h0444);
        clock_recovery[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) clock_recovery[3] = ~clock_recovery[3];
            tick();
            check_value("t6_no_pending3", pending[3], 1'b0);
        end
        clock_recovery = '0;
        ch_en = '1;
        tick(4);

        check_value("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rec_capture_sched
`default_nettype wire
